// File: rtl/phys_regfile_mp.sv
// phys_regfile_mp: multi-port physical register file with per-register ready bits for rename/issue/CDB.
// Optional macro PRF_BYPASS_EN enables same-cycle write-to-read forwarding.
module phys_regfile_mp #(
  parameter int PHYS_REG_BITS = 6,
  parameter int NUM_WR        = 4,
  parameter int NUM_RD        = 8,
  parameter int DATA_W        = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_WR-1:0]               i_wr_en,
  input  logic [NUM_WR*PHYS_REG_BITS-1:0] i_wr_preg,
  input  logic [NUM_WR*5-1:0]             i_wr_arch_rd,
  input  logic [NUM_WR*DATA_W-1:0]        i_wr_data,
  input  logic [NUM_RD*PHYS_REG_BITS-1:0] i_rd_preg,
  input  logic [NUM_RD*5-1:0]             i_rd_arch,
  output logic [NUM_RD*DATA_W-1:0]        o_rd_data,
  output logic [NUM_RD-1:0]               o_rd_ready,
  input  logic                            i_alloc_en,
  input  logic [PHYS_REG_BITS-1:0]        i_alloc_preg,
  input  logic                            i_flush,
  output logic                            o_wr_conflict
);
  localparam int DEPTH = 2**PHYS_REG_BITS;
  logic [DATA_W-1:0]        r_data [DEPTH];
  logic [DEPTH-1:0]         r_ready;
  logic                     r_wr_conflict;
  logic [PHYS_REG_BITS-1:0] w_wp [NUM_WR];
  logic [DATA_W-1:0]        w_wv [NUM_WR];
  logic [NUM_WR-1:0]        w_wact;
  logic                     w_conflict;
  logic [PHYS_REG_BITS-1:0] w_rp [NUM_RD];
  logic [DATA_W-1:0]        w_rv [NUM_RD];
  logic [NUM_RD-1:0]        w_rr;
  logic [NUM_RD-1:0]        w_rz;
  always_comb begin
    w_conflict = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      w_wp[i]   = i_wr_preg[i*PHYS_REG_BITS +: PHYS_REG_BITS];
      w_wv[i]   = (i_wr_arch_rd[i*5 +: 5] != '0) ? i_wr_data[i*DATA_W +: DATA_W] : '0;
      w_wact[i] = i_wr_en[i] && (w_wp[i] != '0);
    end
    for (int i = 0; i < NUM_WR; i++)
      for (int k = i + 1; k < NUM_WR; k++)
        if (w_wact[i] && w_wact[k] && w_wp[i] == w_wp[k]) w_conflict = 1'b1;
  end
  // Writers iterate high-to-low so the lowest port's assignment lands last and wins;
  // allocation then overrides write-ready, and flush overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < DEPTH; d++) r_data[d] <= '0;
      r_ready       <= '1;
      r_wr_conflict <= 1'b0;
    end else begin
      for (int i = NUM_WR - 1; i >= 0; i--)
        if (w_wact[i]) begin
          r_data[w_wp[i]]  <= w_wv[i];
          r_ready[w_wp[i]] <= 1'b1;
        end
      if (i_alloc_en && i_alloc_preg != '0) r_ready[i_alloc_preg] <= 1'b0;
      if (i_flush) r_ready <= '1;
      if (w_conflict) r_wr_conflict <= 1'b1;
    end
  end
  always_comb begin
    o_rd_data  = '0;
    o_rd_ready = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      w_rp[j] = i_rd_preg[j*PHYS_REG_BITS +: PHYS_REG_BITS];
      w_rz[j] = (w_rp[j] == '0) || (i_rd_arch[j*5 +: 5] == '0);
      w_rv[j] = r_data[w_rp[j]];
      w_rr[j] = r_ready[w_rp[j]];
`ifdef PRF_BYPASS_EN
      for (int i = NUM_WR - 1; i >= 0; i--)
        if (rst_n && w_wact[i] && w_wp[i] == w_rp[j]) begin
          w_rv[j] = w_wv[i];
          w_rr[j] = 1'b1;
        end
`endif
      o_rd_data[j*DATA_W +: DATA_W] = w_rz[j] ? '0 : w_rv[j];
      o_rd_ready[j]                 = w_rz[j] | w_rr[j];
    end
  end
  assign o_wr_conflict = r_wr_conflict;
endmodule

// File: tb/tb_phys_regfile_mp.sv
// tb_phys_regfile_mp: directed self-checking bench for phys_regfile_mp (both PRF_BYPASS_EN builds).
module tb_phys_regfile_mp;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  wr_en;
  logic [23:0] wr_preg;
  logic [19:0] wr_arch_rd;
  logic [127:0] wr_data;
  logic [47:0] rd_preg;
  logic [39:0] rd_arch;
  logic [255:0] rd_data;
  logic [7:0]  rd_ready;
  logic        alloc_en;
  logic [5:0]  alloc_preg;
  logic        flush;
  logic        wr_conflict;
  int checks = 0;
  int fails = 0;

  phys_regfile_mp dut (
    .clk(clk), .rst_n(rst_n),
    .i_wr_en(wr_en), .i_wr_preg(wr_preg), .i_wr_arch_rd(wr_arch_rd), .i_wr_data(wr_data),
    .i_rd_preg(rd_preg), .i_rd_arch(rd_arch), .o_rd_data(rd_data), .o_rd_ready(rd_ready),
    .i_alloc_en(alloc_en), .i_alloc_preg(alloc_preg), .i_flush(flush),
    .o_wr_conflict(wr_conflict)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rdd(input int j);
    return rd_data[j*32 +: 32];
  endfunction

  task automatic idle();
    wr_en = '0; wr_preg = '0; wr_arch_rd = '0; wr_data = '0;
    alloc_en = 1'b0; alloc_preg = '0; flush = 1'b0;
  endtask

  task automatic set_wr(input int i, input logic [5:0] p, input logic [4:0] a, input logic [31:0] d);
    wr_en[i] = 1'b1;
    wr_preg[i*6 +: 6] = p;
    wr_arch_rd[i*5 +: 5] = a;
    wr_data[i*32 +: 32] = d;
  endtask

  task automatic set_rd(input int j, input logic [5:0] p, input logic [4:0] a);
    rd_preg[j*6 +: 6] = p;
    rd_arch[j*5 +: 5] = a;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    for (int j = 0; j < 8; j++) set_rd(j, 6'(j*7 + 1), 5'd1);
    #1 rst_n = 1'b0;
    #1;
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (rdd(j) !== 32'h0 || rd_ready[j] !== 1'b1) begin
        $display("FAIL reset_rd%0d: data=%h ready=%b, need data=0 ready=1", j, rdd(j), rd_ready[j]);
        fails++;
      end
    end
    checks++;
    if (wr_conflict !== 1'b0) begin
      $display("FAIL reset_conflict: got %b need 0", wr_conflict); fails++;
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_alloc_write();
    @(negedge clk);
    idle();
    set_rd(0, 6'd5, 5'd1);
    alloc_en = 1'b1; alloc_preg = 6'd5;
    step();
    checks++;
    if (rd_ready[0] !== 1'b0) begin
      $display("FAIL alloc_ready5: got %b need 0", rd_ready[0]); fails++;
    end
    @(negedge clk);
    idle();
    set_wr(2, 6'd5, 5'd3, 32'hDEADBEEF);
    step();
    idle();
    #1;
    checks++;
    if (rdd(0) !== 32'hDEADBEEF || rd_ready[0] !== 1'b1) begin
      $display("FAIL write_p5: data=%h ready=%b, need DEADBEEF/1", rdd(0), rd_ready[0]); fails++;
    end
    set_rd(1, 6'd5, 5'd0);
    #1;
    checks++;
    if (rdd(1) !== 32'h0 || rd_ready[1] !== 1'b1) begin
      $display("FAIL read_arch0: data=%h ready=%b, need 0/1", rdd(1), rd_ready[1]); fails++;
    end
    checks++;
    if (wr_conflict !== 1'b0) begin
      $display("FAIL no_conflict: got %b need 0", wr_conflict); fails++;
    end
  endtask

  task automatic test_conflict();
    @(negedge clk);
    idle();
    set_rd(2, 6'd9, 5'd1);
    set_wr(1, 6'd9, 5'd4, 32'h11111111);
    set_wr(3, 6'd9, 5'd6, 32'h33333333);
    step();
    idle();
    #1;
    checks++;
    if (rdd(2) !== 32'h11111111) begin
      $display("FAIL conflict_data: got %h need 11111111", rdd(2)); fails++;
    end
    checks++;
    if (wr_conflict !== 1'b1) begin
      $display("FAIL conflict_set: got %b need 1", wr_conflict); fails++;
    end
    step();
    step();
    checks++;
    if (wr_conflict !== 1'b1) begin
      $display("FAIL conflict_sticky: got %b need 1", wr_conflict); fails++;
    end
  endtask

  task automatic test_zero_rules();
    @(negedge clk);
    idle();
    set_rd(3, 6'd7, 5'd2);
    set_wr(0, 6'd7, 5'd2, 32'h00000055);
    step();
    checks++;
    if (rdd(3) !== 32'h55) begin
      $display("FAIL p7_prewrite: got %h need 00000055", rdd(3)); fails++;
    end
    @(negedge clk);
    idle();
    set_wr(0, 6'd7, 5'd0, 32'hFFFFFFFF);
    step();
    idle();
    #1;
    checks++;
    if (rdd(3) !== 32'h0 || rd_ready[3] !== 1'b1) begin
      $display("FAIL p7_archzero: data=%h ready=%b, need 0/1", rdd(3), rd_ready[3]); fails++;
    end
    @(negedge clk);
    set_rd(4, 6'd0, 5'd1);
    set_wr(1, 6'd0, 5'd1, 32'hABCDABCD);
    alloc_en = 1'b1; alloc_preg = 6'd0;
    step();
    idle();
    #1;
    checks++;
    if (rdd(4) !== 32'h0 || rd_ready[4] !== 1'b1) begin
      $display("FAIL preg0: data=%h ready=%b, need 0/1", rdd(4), rd_ready[4]); fails++;
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      idle();
      alloc_en = 1'b1; alloc_preg = 6'(10 + k);
      step();
    end
    @(negedge clk);
    idle();
    for (int k = 0; k < 4; k++) set_rd(k, 6'(10 + k), 5'd1);
    #1;
    checks++;
    if (rd_ready[3:0] !== 4'b1000) begin
      $display("FAIL pre_flush_ready: got %b need 1000", rd_ready[3:0]); fails++;
    end
    flush = 1'b1;
    alloc_en = 1'b1; alloc_preg = 6'd13;
    step();
    idle();
    #1;
    checks++;
    if (rd_ready[3:0] !== 4'b1111) begin
      $display("FAIL post_flush_ready: got %b need 1111", rd_ready[3:0]); fails++;
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    idle();
    set_rd(4, 6'd20, 5'd1);
    set_wr(0, 6'd20, 5'd1, 32'h12345678);
    step();
    @(negedge clk);
    idle();
    alloc_en = 1'b1; alloc_preg = 6'd20;
    step();
    @(negedge clk);
    idle();
    set_wr(3, 6'd20, 5'd8, 32'hCAFEF00D);
    #1;
    checks++;
`ifdef PRF_BYPASS_EN
    if (rdd(4) !== 32'hCAFEF00D || rd_ready[4] !== 1'b1) begin
      $display("FAIL bypass_pre: data=%h ready=%b, need CAFEF00D/1", rdd(4), rd_ready[4]); fails++;
    end
`else
    if (rdd(4) !== 32'h12345678 || rd_ready[4] !== 1'b0) begin
      $display("FAIL nobypass_pre: data=%h ready=%b, need 12345678/0", rdd(4), rd_ready[4]); fails++;
    end
`endif
    step();
    idle();
    #1;
    checks++;
    if (rdd(4) !== 32'hCAFEF00D || rd_ready[4] !== 1'b1) begin
      $display("FAIL p20_post: data=%h ready=%b, need CAFEF00D/1", rdd(4), rd_ready[4]); fails++;
    end
    @(negedge clk);
    set_rd(5, 6'd21, 5'd1);
    set_wr(1, 6'd21, 5'd2, 32'h0BADF00D);
    alloc_en = 1'b1; alloc_preg = 6'd21;
    step();
    idle();
    #1;
    checks++;
    if (rdd(5) !== 32'h0BADF00D || rd_ready[5] !== 1'b0) begin
      $display("FAIL alloc_write_same: data=%h ready=%b, need 0BADF00D/0", rdd(5), rd_ready[5]); fails++;
    end
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk);
    idle();
    set_rd(6, 6'd30, 5'd1);
    set_rd(7, 6'd5, 5'd1);
    set_wr(0, 6'd30, 5'd1, 32'h77777777);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (rdd(6) !== 32'h0 || rd_ready[6] !== 1'b1) begin
      $display("FAIL reset_async_read: data=%h ready=%b, need 0/1", rdd(6), rd_ready[6]); fails++;
    end
    checks++;
    if (rdd(7) !== 32'h0 || wr_conflict !== 1'b0) begin
      $display("FAIL reset_clears: p5=%h conflict=%b, need 0/0", rdd(7), wr_conflict); fails++;
    end
    step();
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    #1;
    checks++;
    if (rdd(6) !== 32'h0) begin
      $display("FAIL reset_discard_write: got %h need 0", rdd(6)); fails++;
    end
  endtask

  initial begin
    idle();
    rd_preg = '0;
    rd_arch = '0;
    test_reset();
    test_alloc_write();
    test_conflict();
    test_zero_rules();
    test_flush();
    test_back_to_back();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
